// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and FSM encoding for the MEM-stage access unit.
// The optional response timeout is enabled with the DMEM_TIMEOUT_EN macro.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] WORD_MASK = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } dmem_state_t;

  // Reserved funct3 encodings are reported as misaligned so they never reach memory.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lo);
    logic mis;
    case (funct3)
      F3_B, F3_BU: mis = 1'b0;
      F3_H, F3_HU: mis = lo[0];
      F3_W:        mis = (lo != 2'b00);
      default:     mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_store_align.sv
// dmem_store_align: combinational store-lane replication, word address and
// alignment check for the instruction sitting in the EX/MEM register.
module dmem_store_align
  import dmem_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] lane_wdata,
  output logic [31:0] word_addr,
  output logic        misaligned
);

  assign word_addr  = {addr[31:2], 2'b00};
  assign misaligned = is_misaligned(funct3, addr[1:0]);

  // Replicate the narrow store value into every lane; the byte mask picks the live lane.
  always_comb begin
    lane_wdata = wdata;
    case (funct3)
      F3_B, F3_BU: lane_wdata = {4{wdata[7:0]}};
      F3_H, F3_HU: lane_wdata = {2{wdata[15:0]}};
      default:     lane_wdata = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage load/store sequencer (IDLE -> REQ -> RESP -> DONE).
// Issues one word-aligned request per memory instruction, stalls the pipeline
// until the response returns and holds the raw load word for the formatter.
// Define DMEM_TIMEOUT_EN to abort a response wait after TIMEOUT_CYCLES cycles.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_we,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [2:0]  ex_funct3,
  input  logic [3:0]  fmt_wmask,
  output logic        stall,
  output logic        misaligned,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_we,
  output logic [3:0]  mem_req_wmask,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  output logic [31:0] ld_raw,
  output logic        ld_valid,
  output logic        bus_err
);

  dmem_state_t state_r;
  logic [31:0] lane_wdata;
  logic [31:0] word_addr;
  logic        addr_mis;

  dmem_store_align u_align (
    .addr       (ex_addr),
    .funct3     (ex_funct3),
    .wdata      (ex_wdata),
    .lane_wdata (lane_wdata),
    .word_addr  (word_addr),
    .misaligned (addr_mis)
  );

  // Stall must rise in the accepting IDLE cycle itself, so it is decoded from state and inputs.
  always_comb begin
    stall      = 1'b0;
    misaligned = 1'b0;
    case (state_r)
      ST_IDLE: begin
        stall      = ex_valid & ~addr_mis;
        misaligned = ex_valid & addr_mis;
      end
      ST_REQ:  stall = 1'b1;
      ST_RESP: stall = 1'b1;
      ST_DONE: stall = 1'b0;
      default: stall = 1'b0;
    endcase
  end

`ifdef DMEM_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_cnt_r;
  logic             tmo_hit;

  assign tmo_hit = (tmo_cnt_r == TMO_LAST);

  // Count cycles spent in RESP; held at zero everywhere else so each wait starts fresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r != ST_RESP) begin
      tmo_cnt_r <= {CNT_W{1'b0}};
    end else begin
      tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
    end
  end
`endif

  // Request/response sequencer with registered memory-port and load outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= 32'h0;
      mem_req_we    <= 1'b0;
      mem_req_wmask <= 4'h0;
      mem_req_wdata <= 32'h0;
      ld_raw        <= 32'h0;
      ld_valid      <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      ld_valid <= 1'b0;
      bus_err  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (ex_valid && !addr_mis) begin
            state_r       <= ST_REQ;
            mem_req_valid <= 1'b1;
            mem_req_addr  <= word_addr;
            mem_req_we    <= ex_we;
            mem_req_wmask <= ex_we ? (fmt_wmask & WORD_MASK) : 4'h0;
            mem_req_wdata <= lane_wdata;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            state_r       <= ST_RESP;
            mem_req_valid <= 1'b0;
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_RESP: begin
          if (mem_rsp_valid) begin
            state_r <= ST_DONE;
            if (!mem_req_we) begin
              ld_raw   <= mem_rsp_rdata;
              ld_valid <= 1'b1;
            end
          end
`ifdef DMEM_TIMEOUT_EN
          else if (tmo_hit) begin
            state_r <= ST_DONE;
            bus_err <= 1'b1;
            if (!mem_req_we) begin
              ld_raw   <= 32'h0;
              ld_valid <= 1'b1;
            end
          end
`endif
          else begin
            state_r <= ST_RESP;
          end
        end
        // ex_valid still shows the finished instruction here, so it is not re-sampled.
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed-vector bench for dmem_access_unit.
module tb_dmem_access_unit;
  import dmem_pkg::*;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst, ex_valid, ex_we, mem_req_ready, mem_rsp_valid;
  logic [31:0] ex_addr, ex_wdata, mem_rsp_rdata;
  logic [2:0]  ex_funct3;
  logic [3:0]  fmt_wmask;
  logic        stall, misaligned, mem_req_valid, mem_req_we, ld_valid, bus_err;
  logic [31:0] mem_req_addr, mem_req_wdata, ld_raw;
  logic [3:0]  mem_req_wmask;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-transaction observations.
  int          n_stall, n_ldv, n_hs, n_mis, n_reqv, n_berr, done_cyc;
  logic        unstable;
  logic [31:0] got_addr, got_wdata, got_ld;
  logic        got_we;
  logic [3:0]  got_wm;

  always #5 clk = ~clk;

  dmem_access_unit #(.TIMEOUT_CYCLES(TMO), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_we(ex_we), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .ex_funct3(ex_funct3), .fmt_wmask(fmt_wmask),
    .stall(stall), .misaligned(misaligned), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
    .mem_req_wmask(mem_req_wmask), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .ld_raw(ld_raw), .ld_valid(ld_valid), .bus_err(bus_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one memory instruction and observe it until two cycles past completion.
  // rdy_dly: REQ cycles with ready low; rsp_dly: cycles after handshake (0 = never).
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, input logic [3:0] wm,
                         input int rdy_dly, input int rsp_dly, input logic [31:0] rdata);
    int req_seen;
    int hs_cyc;
    n_stall = 0; n_ldv = 0; n_hs = 0; n_mis = 0; n_reqv = 0; n_berr = 0;
    done_cyc = -1; unstable = 1'b0; req_seen = 0; hs_cyc = -1;
    got_addr = 32'h0; got_wdata = 32'h0; got_we = 1'b0; got_wm = 4'h0;
    ex_valid = 1'b1; ex_we = we; ex_addr = addr; ex_wdata = wdata;
    ex_funct3 = f3; fmt_wmask = wm; mem_rsp_rdata = rdata;
    mem_req_ready = (rdy_dly == 0); mem_rsp_valid = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (stall)      n_stall++;
      if (misaligned) n_mis++;
      if (bus_err)    n_berr++;
      if (ld_valid) begin
        n_ldv++;
        got_ld = ld_raw;
      end
      if (mem_req_valid) begin
        if (req_seen == 0) begin
          got_addr = mem_req_addr; got_we = mem_req_we;
          got_wm = mem_req_wmask; got_wdata = mem_req_wdata;
        end else if (mem_req_addr !== got_addr || mem_req_we !== got_we ||
                     mem_req_wmask !== got_wm || mem_req_wdata !== got_wdata) begin
          unstable = 1'b1;
        end
        req_seen++;
        n_reqv++;
        if (mem_req_ready) begin
          n_hs++;
          hs_cyc = cyc;
        end
      end
      if (done_cyc < 0 && !stall && (hs_cyc < 0 || cyc > hs_cyc)) done_cyc = cyc;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      tick();
      if (done_cyc >= 0) ex_valid = 1'b0;
      mem_req_ready = (hs_cyc < 0) && (req_seen >= rdy_dly);
      mem_rsp_valid = (hs_cyc >= 0) && (rsp_dly > 0) && ((cyc + 1 - hs_cyc) == rsp_dly);
    end
    ex_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    check_eq("txn_completes", (done_cyc >= 0), 32'd1);
    tick();
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_we = 1'b0; ex_addr = 32'h0; ex_wdata = 32'h0;
    ex_funct3 = 3'b000; fmt_wmask = 4'h0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'h0; got_ld = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_stall", stall, 32'd0);
    check_eq("rst_req_valid", mem_req_valid, 32'd0);
    check_eq("rst_req_we", mem_req_we, 32'd0);
    check_eq("rst_req_addr", mem_req_addr, 32'h0);
    check_eq("rst_req_wmask", mem_req_wmask, 32'h0);
    check_eq("rst_req_wdata", mem_req_wdata, 32'h0);
    check_eq("rst_ld_raw", ld_raw, 32'h0);
    check_eq("rst_ld_valid", ld_valid, 32'd0);
    check_eq("rst_bus_err", bus_err, 32'd0);
    check_eq("rst_misaligned", misaligned, 32'd0);
    tick();

    // lw 0x100, ready at once, response two cycles after the handshake.
    run_txn(1'b0, 32'h0000_0100, 32'h0, F3_W, 4'hF, 0, 2, 32'hDEAD_BEEF);
    check_eq("lw_addr", got_addr, 32'h0000_0100);
    check_eq("lw_we", got_we, 32'd0);
    check_eq("lw_wmask", got_wm, 32'h0);
    check_eq("lw_stall_cycles", n_stall, 32'd4);
    check_eq("lw_handshakes", n_hs, 32'd1);
    check_eq("lw_ld_valid_pulses", n_ldv, 32'd1);
    check_eq("lw_ld_raw", got_ld, 32'hDEAD_BEEF);
    check_eq("lw_ld_raw_held", ld_raw, 32'hDEAD_BEEF);
    check_eq("lw_bus_err", n_berr, 32'd0);

    // sb 0x203: byte replicated, word address, store mask passed through.
    run_txn(1'b1, 32'h0000_0203, 32'h0000_00A5, F3_B, 4'b1000, 0, 1, 32'hFFFF_FFFF);
    check_eq("sb_addr", got_addr, 32'h0000_0200);
    check_eq("sb_wdata", got_wdata, 32'hA5A5_A5A5);
    check_eq("sb_wmask", got_wm, 32'h8);
    check_eq("sb_we", got_we, 32'd1);
    check_eq("sb_no_ld_valid", n_ldv, 32'd0);
    check_eq("sb_ld_raw_kept", ld_raw, 32'hDEAD_BEEF);
    check_eq("sb_stall_cycles", n_stall, 32'd3);

    // sh 0x102: halfword replicated into both halves.
    run_txn(1'b1, 32'h0000_0102, 32'h1234_BEEF, F3_H, 4'b1100, 0, 1, 32'h0);
    check_eq("sh_addr", got_addr, 32'h0000_0100);
    check_eq("sh_wdata", got_wdata, 32'hBEEF_BEEF);
    check_eq("sh_wmask", got_wm, 32'hC);

    // sw 0x0FC: full word untouched.
    run_txn(1'b1, 32'h0000_00FC, 32'hCAFE_F00D, F3_W, 4'hF, 0, 1, 32'h0);
    check_eq("sw_wdata", got_wdata, 32'hCAFE_F00D);
    check_eq("sw_addr", got_addr, 32'h0000_00FC);

    // lbu at offset 3 is aligned.
    run_txn(1'b0, 32'h0000_0013, 32'h0, F3_BU, 4'h0, 0, 1, 32'h8899_AABB);
    check_eq("lbu_mis", n_mis, 32'd0);
    check_eq("lbu_addr", got_addr, 32'h0000_0010);
    check_eq("lbu_ld_raw", got_ld, 32'h8899_AABB);

    // Misaligned cases: one pulse, no request, no stall.
    run_txn(1'b1, 32'h0000_0101, 32'h0, F3_H, 4'b0011, 0, 1, 32'h0);
    check_eq("sh_mis_pulse", n_mis, 32'd1);
    check_eq("sh_mis_no_req", n_reqv, 32'd0);
    check_eq("sh_mis_no_stall", n_stall, 32'd0);
    run_txn(1'b0, 32'h0000_0102, 32'h0, F3_W, 4'h0, 0, 1, 32'h0);
    check_eq("lw_mis_pulse", n_mis, 32'd1);
    check_eq("lw_mis_no_req", n_reqv, 32'd0);
    run_txn(1'b0, 32'h0000_0103, 32'h0, F3_HU, 4'h0, 0, 1, 32'h0);
    check_eq("lhu_mis_pulse", n_mis, 32'd1);
    run_txn(1'b0, 32'h0000_0000, 32'h0, 3'b011, 4'h0, 0, 1, 32'h0);
    check_eq("rsvd_mis_pulse", n_mis, 32'd1);
    check_eq("rsvd_no_req", n_reqv, 32'd0);

    // Backpressure: ready low for 5 REQ cycles.
    run_txn(1'b0, 32'h0000_0040, 32'h0, F3_W, 4'h0, 5, 1, 32'h0BAD_F00D);
    check_eq("bp_req_cycles", n_reqv, 32'd6);
    check_eq("bp_stable", unstable, 32'd0);
    check_eq("bp_handshakes", n_hs, 32'd1);
    check_eq("bp_stall_cycles", n_stall, 32'd8);
    check_eq("bp_addr", got_addr, 32'h0000_0040);
    check_eq("bp_ld_raw", got_ld, 32'h0BAD_F00D);

    // Response pulse while idle is ignored.
    mem_rsp_rdata = 32'h5555_AAAA; mem_rsp_valid = 1'b1;
    tick();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    check_eq("idle_rsp_ld_valid", ld_valid, 32'd0);
    check_eq("idle_rsp_ld_raw", ld_raw, 32'h0BAD_F00D);
    tick();

    // Reset while in RESP, then a late response.
    ex_valid = 1'b1; ex_we = 1'b0; ex_addr = 32'h0000_0080; ex_funct3 = F3_W;
    mem_req_ready = 1'b1;
    tick();                       // REQ, handshake at next edge
    tick();                       // RESP
    mem_req_ready = 1'b0;
    @(negedge clk);
    check_eq("rr_in_resp_stall", stall, 32'd1);
    tick();
    rst = 1'b1; ex_valid = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rr_stall", stall, 32'd0);
    check_eq("rr_req_valid", mem_req_valid, 32'd0);
    tick();
    mem_rsp_rdata = 32'h1234_5678; mem_rsp_valid = 1'b1;
    tick();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    check_eq("rr_late_ld_valid", ld_valid, 32'd0);
    check_eq("rr_late_ld_raw", ld_raw, 32'h0);
    check_eq("rr_late_stall", stall, 32'd0);
    tick();

`ifdef DMEM_TIMEOUT_EN
    // Load with no response: abort after TMO cycles in RESP.
    run_txn(1'b0, 32'h0000_0300, 32'h0, F3_W, 4'h0, 0, 0, 32'h0);
    check_eq("tmo_bus_err", n_berr, 32'd1);
    check_eq("tmo_ld_valid", n_ldv, 32'd1);
    check_eq("tmo_ld_raw", got_ld, 32'h0);
    check_eq("tmo_stall_cycles", n_stall, 32'(TMO + 2));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
